// File: rtl/address_sequencer_pkg.sv
// Shared encodings for the address sequencer: opcodes, register-file control codes and FSM states.
package address_sequencer_pkg;

    typedef enum logic [2:0] {
        OpFetch = 3'b000,
        OpPush  = 3'b001,
        OpPop   = 3'b010,
        OpCall  = 3'b011,
        OpRet   = 3'b100,
        OpJump  = 3'b101,
        OpLdar  = 3'b110,
        OpNop   = 3'b111
    } cmd_op_e;

    localparam logic [2:0] FunDec  = 3'b000;
    localparam logic [2:0] FunInc  = 3'b001;
    localparam logic [2:0] FunLoad = 3'b010;
    localparam logic [2:0] FunClr  = 3'b011;

    // Register enables are active-low: a zero bit selects that register.
    localparam logic [2:0] RegNone = 3'b111;
    localparam logic [2:0] RegPc   = 3'b011;
    localparam logic [2:0] RegAr   = 3'b101;
    localparam logic [2:0] RegSp   = 3'b110;
    localparam logic [2:0] RegPcSp = 3'b010;

    localparam logic [1:0] OutPc = 2'b00;
    localparam logic [1:0] OutAr = 2'b10;
    localparam logic [1:0] OutSp = 2'b11;

    typedef enum logic [2:0] {
        StInit = 3'd0,
        StIdle = 3'd1,
        StS1   = 3'd2,
        StS2   = 3'd3,
        StS3   = 3'd4
    } state_e;

    function automatic logic is_last_state(state_e st, cmd_op_e op);
        unique case (op)
            OpJump, OpLdar, OpNop:         return st == StS1;
            OpFetch, OpPush, OpPop, OpRet: return st == StS2;
            OpCall:                        return st == StS3;
            default:                       return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/address_sequencer.sv
// Sequences PC/AR/SP register-file controls and memory strobes for one address command at a time.
module address_sequencer
    import address_sequencer_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       cmd_valid_i,
    input  logic [2:0] cmd_op_i,
    output logic       cmd_ready_o,
    output logic [2:0] fun_sel_o,
    output logic [2:0] reg_sel_o,
    output logic [1:0] out_c_sel_o,
    output logic [1:0] out_d_sel_o,
    output logic       i_sel_o,
    output logic       wd_sel_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_load_o,
    output logic       d_load_o,
    output logic       done_o
);

    state_e  state_q, state_d;
    cmd_op_e op_q, op_d;
    logic    done_q, done_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StInit;
            op_q    <= OpNop;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        done_d  = 1'b0;
        case (state_q)
            StInit: state_d = StIdle;
            StIdle: begin
                if (cmd_valid_i) begin
                    op_d    = cmd_op_e'(cmd_op_i);
                    state_d = StS1;
                end
            end
            StS1, StS2, StS3: begin
                if (is_last_state(state_q, op_q)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    state_d = (state_q == StS1) ? StS2 : StS3;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_comb begin
        cmd_ready_o = (state_q == StIdle);
        fun_sel_o   = FunDec;
        reg_sel_o   = RegNone;
        out_c_sel_o = OutPc;
        out_d_sel_o = OutPc;
        i_sel_o     = 1'b0;
        wd_sel_o    = 1'b0;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        ir_load_o   = 1'b0;
        d_load_o    = 1'b0;
        done_o      = done_q;

        // INIT only drives the clear once reset is released; while held, outputs stay at defaults.
        if (state_q == StInit && rst_ni) begin
            fun_sel_o = FunClr;
            reg_sel_o = RegPcSp;
        end

        case (op_q)
            OpFetch: begin
                if (state_q == StS1) begin
                    out_d_sel_o = OutPc;
                    mem_read_o  = 1'b1;
                    ir_load_o   = 1'b1;
                end else if (state_q == StS2) begin
                    fun_sel_o = FunInc;
                    reg_sel_o = RegPc;
                end
            end
            OpPush: begin
                if (state_q == StS1) begin
                    fun_sel_o = FunDec;
                    reg_sel_o = RegSp;
                end else if (state_q == StS2) begin
                    out_d_sel_o = OutSp;
                    mem_write_o = 1'b1;
                end
            end
            OpPop: begin
                if (state_q == StS1) begin
                    out_d_sel_o = OutSp;
                    mem_read_o  = 1'b1;
                    d_load_o    = 1'b1;
                end else if (state_q == StS2) begin
                    fun_sel_o = FunInc;
                    reg_sel_o = RegSp;
                end
            end
            OpCall: begin
                if (state_q == StS1) begin
                    fun_sel_o = FunDec;
                    reg_sel_o = RegSp;
                end else if (state_q == StS2) begin
                    out_d_sel_o = OutSp;
                    out_c_sel_o = OutPc;
                    wd_sel_o    = 1'b1;
                    mem_write_o = 1'b1;
                end else if (state_q == StS3) begin
                    fun_sel_o = FunLoad;
                    reg_sel_o = RegPc;
                end
            end
            OpRet: begin
                if (state_q == StS1) begin
                    out_d_sel_o = OutSp;
                    mem_read_o  = 1'b1;
                    i_sel_o     = 1'b1;
                    fun_sel_o   = FunLoad;
                    reg_sel_o   = RegPc;
                end else if (state_q == StS2) begin
                    fun_sel_o = FunInc;
                    reg_sel_o = RegSp;
                end
            end
            OpJump: begin
                if (state_q == StS1) begin
                    fun_sel_o = FunLoad;
                    reg_sel_o = RegPc;
                end
            end
            OpLdar: begin
                if (state_q == StS1) begin
                    fun_sel_o = FunLoad;
                    reg_sel_o = RegAr;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_address_sequencer.sv
// Drives address_sequencer against a behavioural register file and memory, scoreboarding each command.
module tb_address_sequencer;
    import address_sequencer_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       cmd_valid_i = 1'b0;
    logic [2:0] cmd_op_i = 3'b111;
    logic       cmd_ready_o;
    logic [2:0] fun_sel_o;
    logic [2:0] reg_sel_o;
    logic [1:0] out_c_sel_o;
    logic [1:0] out_d_sel_o;
    logic       i_sel_o;
    logic       wd_sel_o;
    logic       mem_read_o;
    logic       mem_write_o;
    logic       ir_load_o;
    logic       d_load_o;
    logic       done_o;

    address_sequencer dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cmd_valid_i (cmd_valid_i),
        .cmd_op_i    (cmd_op_i),
        .cmd_ready_o (cmd_ready_o),
        .fun_sel_o   (fun_sel_o),
        .reg_sel_o   (reg_sel_o),
        .out_c_sel_o (out_c_sel_o),
        .out_d_sel_o (out_d_sel_o),
        .i_sel_o     (i_sel_o),
        .wd_sel_o    (wd_sel_o),
        .mem_read_o  (mem_read_o),
        .mem_write_o (mem_write_o),
        .ir_load_o   (ir_load_o),
        .d_load_o    (d_load_o),
        .done_o      (done_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Behavioural register file, instruction/data registers and memory.
    logic [15:0] pc = 16'hDEAD, ar = 16'hBEEF, sp = 16'hDEAD, ir = 16'h0, dr = 16'h0;
    logic [15:0] tgt = 16'h0;
    logic [15:0] mem [int];

    bit          poke_mem_en = 1'b0, poke_sp_en = 1'b0, poke_dr_en = 1'b0;
    int          poke_addr = 0;
    logic [15:0] poke_data = 16'h0, poke_sp = 16'h0, poke_dr = 16'h0;

    function automatic logic [15:0] rd(int a);
        return mem.exists(a) ? mem[a] : 16'h0000;
    endfunction

    function automatic logic [15:0] sel_reg(logic [1:0] s);
        case (s)
            2'b00:   return pc;
            2'b10:   return ar;
            2'b11:   return sp;
            default: return 16'hxxxx;
        endcase
    endfunction

    function automatic logic [15:0] apply(logic [2:0] fs, logic [15:0] q, logic [15:0] iv);
        case (fs)
            3'b000:  return q - 16'd1;
            3'b001:  return q + 16'd1;
            3'b010:  return iv;
            3'b011:  return 16'h0000;
            default: return q;
        endcase
    endfunction

    always @(posedge clk_i) begin : env
        logic [15:0] a, rdata, ival, wdata;
        a     = sel_reg(out_d_sel_o);
        rdata = rd(int'(a));
        ival  = i_sel_o ? rdata : tgt;
        wdata = wd_sel_o ? sel_reg(out_c_sel_o) : dr;
        if (mem_write_o) mem[int'(a)] = wdata;
        if (ir_load_o) ir <= rdata;
        if (d_load_o) dr <= rdata;
        if (!reg_sel_o[2]) pc <= apply(fun_sel_o, pc, ival);
        if (!reg_sel_o[1]) ar <= apply(fun_sel_o, ar, ival);
        if (!reg_sel_o[0]) sp <= apply(fun_sel_o, sp, ival);
        if (poke_mem_en) mem[poke_addr] = poke_data;
        if (poke_sp_en) sp <= poke_sp;
        if (poke_dr_en) dr <= poke_dr;
    end

    typedef struct {
        string       name;
        int          done_cyc;
        logic [15:0] pc, ar, sp, ir, dr;
        int          maddr;
        logic [15:0] mdata;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   dones = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(string name, logic [15:0] epc, logic [15:0] ear, logic [15:0] esp,
                                logic [15:0] eir, logic [15:0] edr, int maddr, logic [15:0] mdata);
        exp_t e;
        e.name = name; e.done_cyc = 0;
        e.pc = epc; e.ar = ear; e.sp = esp; e.ir = eir; e.dr = edr;
        e.maddr = maddr; e.mdata = mdata;
        return e;
    endfunction

    // Monitor: every Done pulse retires the oldest expected command.
    always @(negedge clk_i) begin : monitor
        exp_t e;
        if (rst_ni && done_o) begin
            dones++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_latency"}, cyc, e.done_cyc);
                chk({e.name, "_ready"}, cmd_ready_o, 1);
                chk({e.name, "_pc"}, pc, e.pc);
                chk({e.name, "_ar"}, ar, e.ar);
                chk({e.name, "_sp"}, sp, e.sp);
                chk({e.name, "_ir"}, ir, e.ir);
                chk({e.name, "_dr"}, dr, e.dr);
                if (e.maddr >= 0) chk({e.name, "_mem"}, rd(e.maddr), e.mdata);
            end
        end
    end

    task automatic poke(input bit m_en, input int m_addr, input logic [15:0] m_data,
                        input bit s_en, input logic [15:0] s_val,
                        input bit d_en, input logic [15:0] d_val);
        poke_mem_en = m_en; poke_addr = m_addr; poke_data = m_data;
        poke_sp_en = s_en; poke_sp = s_val;
        poke_dr_en = d_en; poke_dr = d_val;
        @(posedge clk_i);
        #1;
        poke_mem_en = 1'b0; poke_sp_en = 1'b0; poke_dr_en = 1'b0;
        @(negedge clk_i);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [15:0] t, input int lat,
                         input exp_t e, input bit hold);
        int n = 0;
        cmd_op_i = op; tgt = t; cmd_valid_i = 1'b1;
        while (!cmd_ready_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        if (!cmd_ready_o) begin
            chk({e.name, "_accept_timeout"}, 32'd0, 32'd1);
            cmd_valid_i = 1'b0;
            return;
        end
        e.done_cyc = cyc + 1 + lat;
        sb.push_back(e);
        @(negedge clk_i);
        if (!hold) cmd_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk_i);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk_i);
        poke(1'b1, 0, 16'hABCD, 1'b0, 16'h0, 1'b0, 16'h0);
        chk("rst_ready", cmd_ready_o, 0);
        chk("rst_funsel", fun_sel_o, 3'b000);
        chk("rst_regsel", reg_sel_o, 3'b111);
        chk("rst_done", done_o, 0);

        rst_ni = 1'b1;
        #1;
        chk("init_funsel", fun_sel_o, 3'b011);
        chk("init_regsel", reg_sel_o, 3'b010);
        chk("init_ready", cmd_ready_o, 0);
        @(negedge clk_i);
        chk("idle_ready", cmd_ready_o, 1);
        chk("init_pc", pc, 16'h0000);
        chk("init_sp", sp, 16'h0000);
        chk("init_ar_untouched", ar, 16'hBEEF);

        issue(OpFetch, 16'h0, 2, mk("fetch", 16'h0001, 16'hBEEF, 16'h0000, 16'hABCD, 16'h0000, -1, 16'h0), 1'b0);
        drain();

        poke(1'b0, 0, 16'h0, 1'b0, 16'h0, 1'b1, 16'h1234);
        issue(OpPush, 16'h0, 2, mk("push", 16'h0001, 16'hBEEF, 16'hFFFF, 16'hABCD, 16'h1234, 'hFFFF, 16'h1234), 1'b0);
        drain();

        poke(1'b0, 0, 16'h0, 1'b0, 16'h0, 1'b1, 16'h0000);
        issue(OpPop, 16'h0, 2, mk("pop", 16'h0001, 16'hBEEF, 16'h0000, 16'hABCD, 16'h1234, 'hFFFF, 16'h1234), 1'b0);
        drain();

        issue(OpJump, 16'h0010, 1, mk("jump", 16'h0010, 16'hBEEF, 16'h0000, 16'hABCD, 16'h1234, -1, 16'h0), 1'b0);
        drain();
        poke(1'b0, 0, 16'h0, 1'b1, 16'h0100, 1'b0, 16'h0);

        issue(OpCall, 16'h0200, 3, mk("call", 16'h0200, 16'hBEEF, 16'h00FF, 16'hABCD, 16'h1234, 'h00FF, 16'h0010), 1'b0);
        drain();
        issue(OpRet, 16'h0000, 2, mk("ret", 16'h0010, 16'hBEEF, 16'h0100, 16'hABCD, 16'h1234, 'h00FF, 16'h0010), 1'b0);
        drain();

        // Valid held throughout; the LDAR opcode shows up while the JUMP is still busy.
        issue(OpJump, 16'h0040, 1, mk("jump_b2b", 16'h0040, 16'hBEEF, 16'h0100, 16'hABCD, 16'h1234, -1, 16'h0), 1'b1);
        cmd_op_i = OpLdar;
        @(negedge clk_i);
        issue(OpLdar, 16'h0050, 1, mk("ldar_b2b", 16'h0040, 16'h0050, 16'h0100, 16'hABCD, 16'h1234, -1, 16'h0), 1'b0);
        drain();
        chk("done_pulses", dones, 8);

        // Reset in the middle of a CALL, while the stack write is being strobed.
        cmd_op_i = OpCall; tgt = 16'h0300; cmd_valid_i = 1'b1;
        chk("abort_ready", cmd_ready_o, 1);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        @(negedge clk_i);
        chk("abort_s2_memwrite", mem_write_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("abort_memwrite_drop", mem_write_o, 0);
        chk("abort_regsel", reg_sel_o, 3'b111);
        chk("abort_ready_low", cmd_ready_o, 0);
        repeat (2) @(negedge clk_i);
        chk("abort_mem_unchanged", rd('h00FF), 16'h0010);
        chk("abort_sp_left_dec", sp, 16'h00FF);
        chk("abort_pc_unchanged", pc, 16'h0040);
        rst_ni = 1'b1;
        #1;
        chk("reinit_funsel", fun_sel_o, 3'b011);
        chk("reinit_regsel", reg_sel_o, 3'b010);
        @(negedge clk_i);
        chk("reinit_ready", cmd_ready_o, 1);
        chk("reinit_pc", pc, 16'h0000);
        chk("reinit_sp", sp, 16'h0000);
        repeat (2) @(negedge clk_i);
        chk("final_done_count", dones, 8);
        chk("final_sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/address_sequencer.md
# address_sequencer

Control-side driver for the address register file (PC, AR, SP). Accepts one address command at a time over a valid/ready handshake and sequences the register file's FunSel/RegSel/OutCSel/OutDSel controls plus memory strobes over 1–3 cycles. It implements instruction fetch, stack push/pop, call/return, jump and AR load. It sits between the instruction decoder and the address register file/memory.

## Interface
- No parameters.
- Clock  in  1  system clock; all state changes on the rising edge
- Reset  in  1  asynchronous, active-low; forces INIT state and the reset values below
- CmdValid  in  1  command present
- CmdOp  in  3  000 FETCH, 001 PUSH, 010 POP, 011 CALL, 100 RET, 101 JUMP, 110 LDAR, 111 NOP
- CmdReady  out  1  high only in IDLE
- FunSel  out  3  to register file: 000 Q-1, 001 Q+1, 010 load I, 011 clear
- RegSel  out  3  to register file, active-low enables: bit2 PC, bit1 AR, bit0 SP
- OutCSel  out  2  00 PC, 10 AR, 11 SP
- OutDSel  out  2  memory address select, same encoding as OutCSel
- ISel  out  1  register-file I source: 0 command target bus, 1 memory read data
- WDSel  out  1  memory write data: 0 external data register, 1 OutC
- MemRead  out  1  memory read strobe; memory read data is combinational
- MemWrite  out  1  memory write strobe, sampled at the clock edge
- IRLoad  out  1  instruction register captures memory data this edge
- DLoad  out  1  external data register captures memory data this edge
- Done  out  1  one-cycle pulse after a command's last control cycle

## Operation
- States: INIT, IDLE, S1, S2, S3. Command and op are latched on the accepting edge (CmdValid && CmdReady).
- INIT (one cycle after reset release): FunSel=011, RegSel=010 (clear PC and SP) -> IDLE.
- Defaults in every cycle unless listed: RegSel=111, FunSel=000, OutCSel=00, OutDSel=00, ISel=0, WDSel=0, all strobes 0.
- FETCH: S1 OutDSel=00, MemRead, IRLoad; S2 FunSel=001, RegSel=011 (PC+1).
- PUSH: S1 FunSel=000, RegSel=110 (SP-1); S2 OutDSel=11, WDSel=0, MemWrite. SP points to the last pushed word.
- POP: S1 OutDSel=11, MemRead, DLoad; S2 FunSel=001, RegSel=110.
- CALL: S1 SP-1; S2 OutDSel=11, OutCSel=00, WDSel=1, MemWrite; S3 FunSel=010, RegSel=011, ISel=0.
- RET: S1 OutDSel=11, MemRead, ISel=1, FunSel=010, RegSel=011; S2 SP+1.
- JUMP: S1 FunSel=010, RegSel=011, ISel=0. LDAR: S1 FunSel=010, RegSel=101, ISel=0.
- NOP: S1 with default outputs only.
- After the last state the FSM returns to IDLE.
- SP wraps modulo 2^16: push from 0000 writes at FFFF, pop from FFFF leaves 0000. No overflow detection.

## Timing
- All control outputs are Moore, decoded from registered state and latched op. Done is registered.
- Control-cycle counts: FETCH 2, PUSH 2, POP 2, CALL 3, RET 2, JUMP 1, LDAR 1, NOP 1.
- Done rises on the edge leaving the last state. It coincides with IDLE and CmdReady=1.
- A new command can be accepted in the same cycle that Done is high, giving back-to-back throughput of (latency+1) cycles.
- CmdOp is ignored while CmdReady=0, and CmdValid may stay asserted.
- Reset assertion mid-command aborts immediately:
  - outputs go to reset values asynchronously;
  - a partial PUSH or CALL leaves SP decremented, with no repair.
- Reset values: CmdReady=0, FunSel=000, RegSel=111, OutCSel=00, OutDSel=00, ISel=0, WDSel=0, MemRead=0, MemWrite=0, IRLoad=0, DLoad=0, Done=0. State=INIT.

## Structure
- Shared package: opcode constants, FunSel codes (DEC/INC/LOAD/CLR), RegSel one-hot-low masks (PC/AR/SP), OutSel codes, and the state enum.
- Single module, no sub-modules: the state register plus one combinational output decoder.

## Test plan
- Reset, then release: one INIT cycle with FunSel=011, RegSel=010; CmdReady=1 on the next cycle; PC=SP=0000 in the attached register file.
- FETCH with memory[0000]=ABCD: IR=ABCD, PC=0001, Done two cycles after accept plus one.
- PUSH data 1234 from SP=0000: memory[FFFF]=1234, SP=FFFF. Then POP: data register=1234, SP=0000.
- PC=0010, SP=0100, CALL target 0200: memory[00FF]=0010, SP=00FF, PC=0200. Then RET: PC=0010, SP=0100.
- CmdValid held high with JUMP 0040 then LDAR 0050 back-to-back: each is accepted only when CmdReady=1; PC=0040, AR=0050, and exactly two Done pulses.
- Reset asserted during CALL S2: MemWrite drops immediately, memory is unchanged, and the FSM restarts at INIT.
